// File: rtl/mem_line_pkg.sv
// Shared types and helpers for the cache line memory engine.
// Holds the FSM encoding, default line geometry and line-base masking.
package mem_line_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB,
    ST_TURN,
    ST_RD,
    ST_RD_DRAIN,
    ST_DONE
  } line_state_e;

  localparam int LINE_WORDS_DEF = 4;
  localparam int WORD_OFF_W     = $clog2(LINE_WORDS_DEF);
  localparam int LINE_OFF_W     = WORD_OFF_W + 2;

  function automatic logic [63:0] line_base(input logic [63:0] addr, input int off_w);
    return addr & ~((64'd1 << off_w) - 64'd1);
  endfunction

endpackage

// File: rtl/mem_line_engine.sv
// Memory-side initiator: turns one line request into a word-serial writeback
// of the victim line and/or a word-serial fill, returned as a packed line.
module mem_line_engine
  import mem_line_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int ADDR_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_wb,
  input  logic                     req_fill,
  input  logic [ADDR_W-1:0]        req_wb_addr,
  input  logic [ADDR_W-1:0]        req_fill_addr,
  input  logic [32*LINE_WORDS-1:0] req_wb_data,
  output logic                     resp_valid,
  output logic [32*LINE_WORDS-1:0] resp_fill_data,
  output logic                     mem_we,
  output logic                     mem_re,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [31:0]              mem_data_in,
  input  logic [31:0]              mem_data_out
);

  localparam int W_OFF = $clog2(LINE_WORDS);
  localparam int L_OFF = W_OFF + 2;

  line_state_e st, st_nxt;
  logic [W_OFF-1:0]        cnt, cnt_nxt;
  logic [W_OFF-1:0]        cap_idx;
  logic [ADDR_W-1:0]       wb_base, fill_base, word_off;
  logic [32*LINE_WORDS-1:0] wb_line;
  logic                    fill_pend;
  logic                    accept, last, cap_en;

  assign accept     = req_valid && (st == ST_IDLE);
  assign last       = (cnt == W_OFF'(LINE_WORDS - 1));
  assign word_off   = ADDR_W'({cnt, 2'b00});
  assign req_ready  = (st == ST_IDLE);
  assign resp_valid = (st == ST_DONE);

  // Read data lags the address by one cycle; the drain cycle collects the last word.
  assign cap_en  = ((st == ST_RD) && (cnt != '0)) || (st == ST_RD_DRAIN);
  assign cap_idx = (st == ST_RD_DRAIN) ? cnt : cnt - 1'b1;

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    case (st)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (req_valid) begin
          if (req_wb)        st_nxt = ST_WB;
          else if (req_fill) st_nxt = ST_RD;
          else               st_nxt = ST_DONE;
        end
      end
      ST_WB: begin
        if (last) begin
          cnt_nxt = '0;
          st_nxt  = fill_pend ? ST_TURN : ST_DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_TURN: st_nxt = ST_RD;
      ST_RD: begin
        if (last) st_nxt  = ST_RD_DRAIN;
        else      cnt_nxt = cnt + 1'b1;
      end
      ST_RD_DRAIN: begin
        cnt_nxt = '0;
        st_nxt  = ST_DONE;
      end
      ST_DONE: st_nxt = ST_IDLE;
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    case (st)
      ST_WB: begin
        mem_we      = 1'b1;
        mem_addr    = wb_base + word_off;
        mem_data_in = wb_line[32*cnt +: 32];
      end
      ST_RD, ST_RD_DRAIN: begin
        mem_re   = 1'b1;
        mem_addr = fill_base + word_off;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st             <= ST_IDLE;
      cnt            <= '0;
      fill_pend      <= 1'b0;
      resp_fill_data <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
      if (accept) fill_pend <= req_fill;
      if (cap_en) resp_fill_data[32*cap_idx +: 32] <= mem_data_out;
    end
  end

  // Request capture: addresses are aligned once here so the bus side never carries out of the line.
  always_ff @(posedge clk) begin
    if (accept) begin
      wb_base   <= ADDR_W'(line_base(64'(req_wb_addr), L_OFF));
      fill_base <= ADDR_W'(line_base(64'(req_fill_addr), L_OFF));
      wb_line   <= req_wb_data;
    end
  end

endmodule

// File: tb/tb_mem_line_engine.sv
// Scoreboard bench for mem_line_engine: expected bus accesses and responses are
// queued at request time and compared as the engine produces them.
module tb_mem_line_engine;

  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int LW   = 32 * N;
  localparam int LOFF = $clog2(N) + 2;

  typedef struct {
    int          off;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  typedef struct {
    int          lat;
    logic [LW-1:0] fill;
  } resp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wb = 1'b0;
  logic          req_fill = 1'b0;
  logic [AW-1:0] req_wb_addr = '0;
  logic [AW-1:0] req_fill_addr = '0;
  logic [LW-1:0] req_wb_data = '0;
  logic          resp_valid;
  logic [LW-1:0] resp_fill_data;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data_in;
  logic [31:0]   mem_data_out = '0;

  always #5 clk = ~clk;

  mem_line_engine #(.LINE_WORDS(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wb(req_wb), .req_fill(req_fill),
    .req_wb_addr(req_wb_addr), .req_fill_addr(req_fill_addr),
    .req_wb_data(req_wb_data),
    .resp_valid(resp_valid), .resp_fill_data(resp_fill_data),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  logic [31:0] ram [0:1023];
  logic [31:0] mdl [0:1023];

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[11:2]] <= mem_data_in;
    mem_data_out <= mem_re ? ram[mem_addr[11:2]] : 32'hDEAD_BEEF;
  end

  int n_checks = 0;
  int n_err    = 0;
  int cyc_n    = 0;
  int acc_cyc  = 0;
  bit done     = 1'b0;
  logic [LW-1:0] exp_fill = '0;
  acc_t  acc_q [$];
  resp_t resp_q[$];

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    acc_t  e;
    resp_t r;
    cyc_n++;
    check("we_re_excl", LW'(mem_we & mem_re), '0);
    if (!mem_we) check("din_idle", LW'(mem_data_in), '0);
    if (!mem_we && !mem_re) check("addr_idle", LW'(mem_addr), '0);
    if (mem_we || mem_re) begin
      if (acc_q.size() == 0) begin
        check("unexp_access", LW'(mem_addr), LW'(32'hFFFF_FFFF));
      end else begin
        e = acc_q.pop_front();
        check("acc_cycle", LW'(cyc_n - acc_cyc), LW'(e.off));
        check("acc_strobe", LW'({mem_we, mem_re}), LW'({e.we, e.re}));
        check("acc_addr", LW'(mem_addr), LW'(e.addr));
        check("acc_din", LW'(mem_data_in), LW'(e.data));
      end
    end
    if (resp_valid) begin
      done = 1'b1;
      if (resp_q.size() == 0) begin
        check("unexp_resp", LW'(1), LW'(0));
      end else begin
        r = resp_q.pop_front();
        check("resp_latency", LW'(cyc_n - acc_cyc), LW'(r.lat));
        check("resp_fill", resp_fill_data, r.fill);
      end
    end
  end

  task automatic drive_req(input bit wb, input bit fill, input logic [31:0] wa,
                           input logic [31:0] fa, input logic [LW-1:0] wd, input bit hold);
    logic [31:0] wbase, fbase, a;
    int off, lat, t;
    wbase = wa & ~((32'd1 << LOFF) - 32'd1);
    fbase = fa & ~((32'd1 << LOFF) - 32'd1);
    a   = '0;
    off = 1;
    if (wb) begin
      for (int i = 0; i < N; i++) begin
        a = wbase + 32'(4 * i);
        acc_q.push_back('{off, 1'b1, 1'b0, a, wd[32*i +: 32]});
        mdl[a[11:2]] = wd[32*i +: 32];
        off++;
      end
      if (fill) off++;
    end
    if (fill) begin
      for (int i = 0; i < N; i++) begin
        a = fbase + 32'(4 * i);
        acc_q.push_back('{off, 1'b0, 1'b1, a, 32'h0});
        exp_fill[32*i +: 32] = mdl[a[11:2]];
        off++;
      end
      acc_q.push_back('{off, 1'b0, 1'b1, a, 32'h0});
    end
    if (wb && fill) lat = 2 * N + 3;
    else if (wb)    lat = N + 1;
    else if (fill)  lat = N + 2;
    else            lat = 1;
    resp_q.push_back('{lat, exp_fill});

    @(negedge clk);
    req_wb = wb; req_fill = fill;
    req_wb_addr = wa; req_fill_addr = fa; req_wb_data = wd;
    req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) check("accept_timeout", LW'(req_ready), LW'(1));
    @(posedge clk);
    acc_cyc = cyc_n;
    done    = 1'b0;
    #1;
    if (!hold) begin
      req_valid     = 1'b0;
      req_wb        = 1'($urandom);
      req_fill      = 1'($urandom);
      req_wb_addr   = $urandom;
      req_fill_addr = $urandom;
      req_wb_data   = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic wait_done(input bit hold);
    int t;
    t = 0;
    while (!done && t < 100) begin
      @(negedge clk);
      #1;
      if (hold) check("ready_busy", LW'(req_ready), LW'(0));
      t++;
    end
    if (!done) check("resp_timeout", LW'(done), LW'(1));
    req_valid = 1'b0;
    @(negedge clk);
    check("acc_left", LW'(acc_q.size()), LW'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] line_a, line_d;
    int t;
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 32'h1000_0000 ^ (32'(i) * 32'h0001_0003);
      mdl[i] = ram[i];
    end
    for (int i = 0; i < N; i++) begin
      ram[32'h40 + i] = 32'hA0A0_0000 + 32'(i);
      mdl[32'h40 + i] = ram[32'h40 + i];
      line_a[32*i +: 32] = 32'hA0A0_0000 + 32'(i);
      line_d[32*i +: 32] = 32'hD0D0_0000 + 32'(i);
    end

    #12;
    check("rst_ready", LW'(req_ready), LW'(1));
    check("rst_resp_valid", LW'(resp_valid), LW'(0));
    check("rst_strobes", LW'({mem_we, mem_re}), LW'(0));
    check("rst_addr", LW'(mem_addr), LW'(0));
    check("rst_fill_data", resp_fill_data, '0);
    @(negedge clk);
    rst = 1'b0;

    // fill-only from an aligned line
    drive_req(1'b0, 1'b1, 32'h0, 32'h100, '0, 1'b0);
    wait_done(1'b0);
    check("fill_A_line", resp_fill_data, line_a);

    // writeback-only, then read the same line back
    drive_req(1'b1, 1'b0, 32'h200, 32'h0, line_d, 1'b0);
    wait_done(1'b0);
    check("wb_keeps_fill", resp_fill_data, line_a);
    drive_req(1'b0, 1'b1, 32'h0, 32'h200, '0, 1'b0);
    wait_done(1'b0);
    check("wb_readback", resp_fill_data, line_d);

    // writeback + fill
    drive_req(1'b1, 1'b1, 32'h300, 32'h400, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    wait_done(1'b0);

    // unaligned fill with req_valid held through the operation
    drive_req(1'b0, 1'b1, 32'h0, 32'h10F, '0, 1'b1);
    wait_done(1'b1);
    check("unaligned_fill", resp_fill_data, line_a);

    // null request leaves the returned line alone
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, '0, 1'b0);
    wait_done(1'b0);
    check("null_keeps_fill", resp_fill_data, line_a);

    // fill at the top of the address space
    drive_req(1'b0, 1'b1, 32'h0, 32'hFFFF_FFF4, '0, 1'b0);
    wait_done(1'b0);

    // writeback and fill of the same line return the written data
    drive_req(1'b1, 1'b1, 32'h500, 32'h504, line_d ^ {LW{1'b1}}, 1'b0);
    wait_done(1'b0);
    check("wb_fill_same", resp_fill_data, line_d ^ {LW{1'b1}});

    // reset during the third read cycle
    drive_req(1'b0, 1'b1, 32'h0, 32'h200, '0, 1'b0);
    t = 0;
    while ((cyc_n - acc_cyc) < 3 && t < 20) begin
      @(negedge clk);
      #2;
      t++;
    end
    rst = 1'b1;
    #1;
    check("abort_strobes", LW'({mem_we, mem_re}), LW'(0));
    check("abort_resp", LW'(resp_valid), LW'(0));
    check("abort_ready", LW'(req_ready), LW'(1));
    check("abort_fill_clr", resp_fill_data, '0);
    acc_q.delete();
    resp_q.delete();
    exp_fill = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_no_resp", LW'(resp_valid), LW'(0));

    // normal fill after the abort
    drive_req(1'b0, 1'b1, 32'h0, 32'h100, '0, 1'b0);
    wait_done(1'b0);
    check("post_abort_fill", resp_fill_data, line_a);
    check("resp_left", LW'(resp_q.size()), LW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_line_engine.md
Name: mem_line_engine

Overview:
- Memory-side initiator for the 2-way set-associative LRU cache controller.
- Converts one line request from the controller into a sequence of single-word accesses on the main RAM port:
  - optional writeback of the dirty victim line;
  - optional fill of the new line.
- Drives the RAM's mem_we/mem_re/mem_addr/mem_data_in and samples its mem_data_out, returning the filled line to the controller.

Parameters:
- LINE_WORDS, 4, 32-bit words per cache line; power of two, 2..16.
- ADDR_W, 32, byte-address width on the RAM port.

Ports:
- clk  in  1  clock; all activity on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  controller request strobe.
- req_ready  out  1  high only in IDLE; request accepted on req_valid && req_ready.
- req_wb  in  1  perform writeback of req_wb_data to req_wb_addr.
- req_fill  in  1  perform fill from req_fill_addr.
- req_wb_addr  in  ADDR_W  victim line byte address; low log2(LINE_WORDS)+2 bits ignored.
- req_fill_addr  in  ADDR_W  fill line byte address; low bits ignored likewise.
- req_wb_data  in  32*LINE_WORDS  victim line; word i at bits [32i+31:32i].
- resp_valid  out  1  one-cycle pulse: operation complete.
- resp_fill_data  out  32*LINE_WORDS  filled line, same packing; held until the next fill is captured.
- mem_we  out  1  RAM write strobe.
- mem_re  out  1  RAM read strobe.
- mem_addr  out  ADDR_W  RAM byte address.
- mem_data_in  out  32  RAM write data.
- mem_data_out  in  32  RAM read data; registered inside RAM, valid while mem_re high.

Behaviour:
- Reset (async): state IDLE; req_ready=1, resp_valid=0, mem_we=0, mem_re=0, mem_addr=0, mem_data_in=0, resp_fill_data=0, word counter=0.
- Reset mid-operation:
  - aborts immediately; strobes drop in the same instant; no completion pulse;
  - partial fill data is discarded (cleared).
- Accept:
  - All request inputs are registered at acceptance; inputs may change afterward.
  - Line base = address with low log2(LINE_WORDS)+2 bits zeroed.
  - Word i address = base + 4*i.
- FSM states: IDLE, WB, TURN, RD, RD_DRAIN, DONE.
  - IDLE -> WB if req_wb; else -> RD if req_fill; else -> DONE.
  - WB: one word per cycle.
    - mem_we=1, mem_re=0, mem_addr = word i, mem_data_in = word i.
    - Counter runs 0..LINE_WORDS-1.
    - After the last word: -> TURN if fill pending, else -> DONE.
  - TURN: one cycle with mem_we=mem_re=0 (bus turnaround), then -> RD.
  - RD: mem_re=1, mem_addr = word i, counter 0..LINE_WORDS-1.
    - From the second RD cycle on, capture mem_data_out into word i-1 on each rising edge.
    - After the last address: -> RD_DRAIN.
  - RD_DRAIN: mem_re=1, mem_addr held at the last word; capture the last word; -> DONE.
  - DONE: resp_valid=1 for exactly one cycle, strobes low; -> IDLE.
- Invariants:
  - mem_we and mem_re are never high in the same cycle.
  - mem_data_in = 0 whenever mem_we=0.
  - mem_addr is 0 in IDLE/TURN/DONE.
- Latency from the accept edge to the resp_valid cycle (N = LINE_WORDS):
  - writeback only: N+1;
  - fill only: N+2;
  - writeback+fill: 2N+3;
  - neither: 1.
- Back-to-back: a new request can be accepted in the cycle after DONE (IDLE, req_ready=1); req_ready is low from accept through DONE.
- Address wrap: base + 4*i computed modulo 2^ADDR_W; no carry out of the line offset, since base is aligned.
- resp_fill_data is unchanged by writeback-only and null operations.

Decomposition:
- Package mem_line_pkg:
  - FSM state enum;
  - WORD_OFF_W = log2(LINE_WORDS);
  - LINE_OFF_W = WORD_OFF_W+2;
  - line-base masking function.
- Single module; no sub-module is warranted. The counter, address generator and capture register are all local.

Test Plan:
- Fill-only, LINE_WORDS=4, RAM preloaded with words A0..A3 at 0x100..0x10C, req_fill_addr=0x100 -> mem_re high 5 cycles, mem_addr sequence 0x100,0x104,0x108,0x10C,0x10C; resp_valid 6 cycles after accept; resp_fill_data={A3,A2,A1,A0}.
- Writeback-only, req_wb_addr=0x200, data {D3,D2,D1,D0} -> 4 mem_we cycles at 0x200..0x20C carrying D0..D3; resp_valid 5 cycles after accept; a later fill of 0x200 returns the same line.
- Writeback+fill, wb 0x300, fill 0x400 -> 4 WB cycles, 1 turnaround with both strobes low, 5 RD cycles, resp_valid at cycle 11; mem_we&&mem_re never observed.
- Unaligned req_fill_addr=0x10F -> accesses start at 0x100; req_valid held during busy -> req_ready low, no second accept until after DONE.
- Assert rst during the 3rd RD cycle -> mem_re/mem_we drop immediately, no resp_valid, resp_fill_data=0, req_ready=1; next fill completes normally.
- Null request (req_wb=req_fill=0) -> no RAM strobes, resp_valid the cycle after accept, resp_fill_data unchanged.
